// File: rtl/fifo_pkg.sv
// Shared sizing constants for the fifo_buf synchronous FIFO and its storage.
package fifo_pkg;

  localparam int unsigned FIFO_ADD_WIDTH  = 5;
  localparam int unsigned FIFO_DATA_WIDTH = 8;
  localparam int unsigned FIFO_DEPTH      = 1 << FIFO_ADD_WIDTH;

endpackage : fifo_pkg

// File: rtl/fifo_ram.sv
// Simple dual-port storage: one synchronous write port, one registered read port.
// A same-address read and write returns the old word (needed for full read+write).
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int unsigned ADD_WIDTH  = FIFO_ADD_WIDTH,
  parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en_i,
  input  logic [ADD_WIDTH-1:0]  wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_dat_i,
  input  logic                  rd_en_i,
  input  logic [ADD_WIDTH-1:0]  rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_dat_o
);

  localparam int unsigned DEPTH = 1 << ADD_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_dat_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_dat_i;
    end
  end

  // Output register is cleared by reset; the array itself is not.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_dat_q <= '0;
    end else if (rd_en_i) begin
      rd_dat_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_dat_o = rd_dat_q;

endmodule : fifo_ram

// File: rtl/fifo_buf.sv
// Synchronous FIFO, 2**ADD_WIDTH words, registered read data one cycle after an accepted read.
// Define FIFO_ERR_FLAGS_EN to add sticky overflow/underflow outputs.
module fifo_buf
  import fifo_pkg::*;
#(
  parameter int unsigned ADD_WIDTH  = FIFO_ADD_WIDTH,
  parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  a_Reset_n,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  Wr_enable,
  input  logic                  Read_enable,
  output logic [DATA_WIDTH-1:0] data_out,
`ifdef FIFO_ERR_FLAGS_EN
  output logic                  overflow,
  output logic                  underflow,
`endif
  output logic                  full,
  output logic                  empty
);

  localparam int unsigned PW = ADD_WIDTH + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          wr_acc;
  logic          rd_acc;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[ADD_WIDTH-1:0] == rd_ptr_q[ADD_WIDTH-1:0]) &&
                 (wr_ptr_q[ADD_WIDTH] != rd_ptr_q[ADD_WIDTH]);

  // When full, a concurrent read frees the slot the write lands in.
  assign rd_acc = Read_enable && !empty;
  assign wr_acc = Wr_enable && (!full || rd_acc);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!a_Reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  always_comb begin
    overflow_d  = overflow_q  || (Wr_enable && !wr_acc);
    underflow_d = underflow_q || (Read_enable && empty);
  end

  always_ff @(posedge clk) begin
    if (!a_Reset_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

  fifo_ram #(
    .ADD_WIDTH  (ADD_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk       (clk),
    .rst_n     (a_Reset_n),
    .wr_en_i   (wr_acc),
    .wr_addr_i (wr_ptr_q[ADD_WIDTH-1:0]),
    .wr_dat_i  (data_in),
    .rd_en_i   (rd_acc),
    .rd_addr_i (rd_ptr_q[ADD_WIDTH-1:0]),
    .rd_dat_o  (data_out)
  );

endmodule : fifo_buf

// File: tb/tb_fifo_buf.sv
// Scoreboard bench for fifo_buf: a queue model predicts acceptance, read data and flags.
module tb_fifo_buf;

  localparam int DEPTH = 32;

  logic       clk = 1'b0;
  logic       a_Reset_n;
  logic [7:0] data_in;
  logic       Wr_enable;
  logic       Read_enable;
  logic [7:0] data_out;
  logic       full;
  logic       empty;
`ifdef FIFO_ERR_FLAGS_EN
  logic       overflow;
  logic       underflow;
  logic       exp_ovf, exp_unf;
`endif

  fifo_buf dut (
    .clk         (clk),
    .a_Reset_n   (a_Reset_n),
    .data_in     (data_in),
    .Wr_enable   (Wr_enable),
    .Read_enable (Read_enable),
    .data_out    (data_out),
`ifdef FIFO_ERR_FLAGS_EN
    .overflow    (overflow),
    .underflow   (underflow),
`endif
    .full        (full),
    .empty       (empty)
  );

  always #5 clk = ~clk;

  int         n_vec  = 0;
  int         n_miss = 0;
  logic [7:0] mdl[$];
  logic [7:0] sb[$];
  logic [7:0] exp_dout;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "/dout"},  32'(data_out), 32'(exp_dout));
    chk({tag, "/empty"}, 32'(empty),    32'(mdl.size() == 0));
    chk({tag, "/full"},  32'(full),     32'(mdl.size() == DEPTH));
`ifdef FIFO_ERR_FLAGS_EN
    chk({tag, "/ovf"},   32'(overflow),  32'(exp_ovf));
    chk({tag, "/unf"},   32'(underflow), 32'(exp_unf));
`endif
  endtask

  // Drive one cycle; the model decides what the DUT must accept.
  task automatic step(input logic wr, input logic rd, input logic [7:0] d, input string tag);
    bit rd_ok, wr_ok;
    Wr_enable   = wr;
    Read_enable = rd;
    data_in     = d;
    rd_ok = rd && (mdl.size() != 0);
    wr_ok = wr && ((mdl.size() != DEPTH) || rd_ok);
`ifdef FIFO_ERR_FLAGS_EN
    if (rd && mdl.size() == 0) exp_unf = 1'b1;
    if (wr && !wr_ok) exp_ovf = 1'b1;
`endif
    if (rd_ok) sb.push_back(mdl.pop_front());
    if (wr_ok) mdl.push_back(d);
    @(posedge clk);
    #1;
    if (sb.size() != 0) exp_dout = sb.pop_front();
    chk_state(tag);
    Wr_enable   = 1'b0;
    Read_enable = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    a_Reset_n   = 1'b0;
    Wr_enable   = 1'b1;
    Read_enable = 1'b1;
    data_in     = 8'hA5;
    @(posedge clk);
    #1;
    mdl.delete();
    sb.delete();
    exp_dout = '0;
`ifdef FIFO_ERR_FLAGS_EN
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
`endif
    chk_state(tag);
    a_Reset_n   = 1'b1;
    Wr_enable   = 1'b0;
    Read_enable = 1'b0;
  endtask

  initial begin
    a_Reset_n   = 1'b0;
    Wr_enable   = 1'b0;
    Read_enable = 1'b0;
    data_in     = '0;
    exp_dout    = '0;
    repeat (2) @(posedge clk);
    #1;
    do_reset("reset");

    // Two writes, then reads through to underflow.
    step(1'b1, 1'b0, 8'd19, "wr19");
    step(1'b1, 1'b0, 8'd20, "wr20");
    step(1'b0, 1'b1, 8'd0,  "rd19");
    step(1'b0, 1'b1, 8'd0,  "rd20");
    step(1'b0, 1'b1, 8'd0,  "rd_empty");

    // Read+write while empty: only the write happens.
    step(1'b1, 1'b1, 8'd55, "wr_rd_empty");
    step(1'b0, 1'b1, 8'd0,  "rd55");

    // Fill past capacity, then drain with extra reads.
    do_reset("reset2");
    for (int i = 0; i < 34; i++) step(1'b1, 1'b0, 8'(100 + i), "fill");
    for (int i = 0; i < 34; i++) step(1'b0, 1'b1, 8'd0, "drain");

    // Refill (write pointer wraps), read+write at full, drain across the wrap.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 8'(200 + i), "refill");
    step(1'b1, 1'b1, 8'd77, "wr_rd_full");
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 8'd0, "drain_wrap");

    // Mixed traffic including simultaneous read/write mid-occupancy.
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom), "rand");

    // Reset mid-operation discards contents.
    do_reset("reset3");
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(i + 1), "pre_rst");
    do_reset("mid_reset");
    step(1'b0, 1'b1, 8'd0, "rd_after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule : tb_fifo_buf
